prog_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the CPU datapath's dual-port RAM.
- Receives a framed byte stream (length header, big-endian 16-bit words, XOR checksum) on a valid/ready interface.
- Writes each assembled word into RAM through the datapath's second RAM port, starting at address 0.
- Holds the CPU core idle (cpu_run low) until a complete frame has loaded with a correct checksum, then releases it.

---
 rtl/prog_loader.sv | 94 +++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// 16-bit RAM words, then releases the CPU once the frame checks out.
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    LenHi, LenLo, ChkLen, DataHi, DataLo, Write, Chk, Done, Error
  } stateT;

  localparam logic [16:0] DepthL = 17'(DEPTH);

  stateT       state, stateNext;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [7:0]  wordHi;
  logic        rxFire;
  logic [15:0] loadedNext;

  assign rxFire     = rx_valid & rx_ready;
  assign loadedNext = 16'(words_loaded) + 16'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LenHi;
    else     state <= stateNext;
  end

  // Next-state logic; Done and Error are absorbing until reset.
  always_comb begin
    stateNext = state;
    case (state)
      LenHi:  if (rxFire) stateNext = LenLo;
      LenLo:  if (rxFire) stateNext = ChkLen;
      ChkLen: begin
        if ({1'b0, len} > DepthL) stateNext = Error;
        else if (len == 16'd0)    stateNext = Chk;
        else                      stateNext = DataHi;
      end
      DataHi: if (rxFire) stateNext = DataLo;
      DataLo: if (rxFire) stateNext = Write;
      Write:  stateNext = (loadedNext == len) ? Chk : DataHi;
      Chk:    if (rxFire) stateNext = (rx_data == csum) ? Done : Error;
      default: stateNext = state;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe, without any path from rx_valid to rx_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      csum         <= '0;
      wordHi       <= '0;
    end else begin
      rx_ready <= stateNext inside {LenHi, LenLo, DataHi, DataLo, Chk};
      mem_we   <= (stateNext == Write);
      cpu_run  <= (stateNext == Done);
      load_err <= (stateNext == Error);
      if (rxFire && (state inside {LenHi, LenLo, DataHi, DataLo}))
        csum <= csum ^ rx_data;
      if (rxFire && state == LenHi)  len[15:8] <= rx_data;
      if (rxFire && state == LenLo)  len[7:0]  <= rx_data;
      if (rxFire && state == DataHi) wordHi    <= rx_data;
      // Address and data are captured with the low byte and then held.
      if (rxFire && state == DataLo) begin
        mem_addr  <= words_loaded[ADDR_W-1:0];
        mem_wdata <= {wordHi, rx_data};
      end
      if (state == Write) words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model queues expected RAM
// writes, a negedge monitor pops them as mem_we pulses appear.
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wrT;

  wrT   sb[$];
  wrT   expWr;
  int   checks = 0;
  int   fails  = 0;
  logic prevFire = 1'b0;
  logic prevWe   = 1'b0;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write must match the model's next queued write, be one cycle wide,
  // follow an accepted byte directly, and coincide with rx_ready low.
  always @(negedge clk) begin
    if (rst) begin
      prevFire = 1'b0;
      prevWe   = 1'b0;
    end else begin
      if (mem_we) begin
        checkOutput("wePulse", 32'(prevWe), 32'd0);
        checkOutput("weLatency", 32'(prevFire), 32'd1);
        checkOutput("readyInWrite", 32'(rx_ready), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpectedWrite: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
        end else begin
          expWr = sb.pop_front();
          checkOutput("wrAddr", 32'(mem_addr), 32'(expWr.addr));
          checkOutput("wrData", 32'(mem_wdata), 32'(expWr.data));
        end
      end
      prevFire = rx_valid & rx_ready;
      prevWe   = mem_we;
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int  n    = 0;
    bit  done = 0;
    bit  acc;
    while (!done && n < 200) begin
      if (gaps && $urandom_range(1) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      acc = rx_valid & rx_ready;
      @(posedge clk);
      #1;
      n++;
      if (acc) done = 1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL byteTimeout: byte %0h not accepted, required within 200 cycles", b);
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "RxReady"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "MemWe"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "MemAddr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "MemWdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "CpuRun"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "LoadErr"}, 32'(load_err), 32'd0);
    checkOutput({tag, "Words"}, 32'(words_loaded), 32'd0);
  endtask

  // Reset is raised mid-cycle so its effect is visible before any clock edge.
  task automatic doReset(input bit check);
    @(posedge clk);
    #3;
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    if (check) checkOutputsZero("midReset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic checkFinal(input bit ok, input int words);
    int n = 0;
    while (!(cpu_run | load_err) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("cpuRun", 32'(cpu_run), 32'(ok));
    checkOutput("loadErr", 32'(load_err), 32'(!ok));
    checkOutput("wordsLoaded", 32'(words_loaded), 32'(words));
    checkOutput("readyTerminal", 32'(rx_ready), 32'd0);
    checkOutput("pendingWrites", 32'(sb.size()), 32'd0);
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    checkOutput("cpuRunHeld", 32'(cpu_run), 32'(ok));
    checkOutput("wordsHeld", 32'(words_loaded), 32'(words));
  endtask

  // Frame model: length, word list and checksum taken straight from the bytes.
  task automatic applyStimulus(input logic [7:0] q[$], input bit gaps);
    int         len;
    int         nSend;
    int         words;
    logic [7:0] cs;
    bit         ok;
    len = int'({q[0], q[1]});
    if (len > DEPTH) begin
      nSend = 2;
      ok    = 0;
      words = 0;
    end else begin
      nSend = 3 + 2 * len;
      cs = 8'd0;
      for (int i = 0; i < nSend - 1; i++) cs ^= q[i];
      for (int k = 0; k < len; k++)
        sb.push_back('{10'(k), {q[2 + 2 * k], q[3 + 2 * k]}});
      ok    = (q[nSend - 1] == cs);
      words = len;
    end
    for (int i = 0; i < nSend; i++) sendByte(q[i], gaps);
    rx_valid = 1'b0;
    checkFinal(ok, words);
  endtask

  function automatic void makeFrame(input int len, input bit corrupt, output logic [7:0] q[$]);
    logic [7:0] cs;
    logic [15:0] l16;
    q.delete();
    l16 = 16'(len);
    q.push_back(l16[15:8]);
    q.push_back(l16[7:0]);
    for (int i = 0; i < 2 * len; i++) q.push_back(8'($urandom));
    cs = 8'd0;
    foreach (q[i]) cs ^= q[i];
    q.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endfunction

  logic [7:0] frame[$];

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutputsZero("reset");
    rst = 1'b0;

    $display("[TB] two-word frame, clean");
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    applyStimulus(frame, 0);

    $display("[TB] two-word frame, bad checksum");
    doReset(0);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    applyStimulus(frame, 0);

    $display("[TB] oversize length 1025");
    doReset(0);
    frame = '{8'h04, 8'h01};
    applyStimulus(frame, 0);

    $display("[TB] zero-length frame");
    doReset(0);
    frame = '{8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 0);

    $display("[TB] two-word frame with valid gaps");
    doReset(0);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    applyStimulus(frame, 1);

    $display("[TB] reset after first word, then reload");
    doReset(0);
    sb.push_back('{10'd0, 16'h1234});
    frame = '{8'h00, 8'h02, 8'h12, 8'h34};
    foreach (frame[i]) sendByte(frame[i], 0);
    rx_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midWords", 32'(words_loaded), 32'd1);
    checkOutput("midWritesDone", 32'(sb.size()), 32'd0);
    doReset(1);
    frame = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE};
    applyStimulus(frame, 0);

    $display("[TB] random frames");
    for (int t = 0; t < 6; t++) begin
      doReset(0);
      makeFrame(int'($urandom_range(1, 8)), (t % 3) == 2, frame);
      applyStimulus(frame, bit'($urandom_range(1)));
    end

    $display("[TB] full-depth frame");
    doReset(0);
    makeFrame(DEPTH, 0, frame);
    applyStimulus(frame, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
